// File: rtl/picomips_pkg.sv
// ---------------------------------------------------------------------------
// picomips_pkg : shared sequencer state type and default core sizes
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package picomips_pkg;

  localparam int PSIZE_DEFAULT      = 6;
  localparam int MUL_CYCLES_DEFAULT = 3;

  typedef enum logic {RUN, MULW} seq_state_t;

endpackage

`default_nettype wire

// File: rtl/picomips_sequencer_if.sv
// ---------------------------------------------------------------------------
// picomips_sequencer_if : decoder <-> sequencer request/status bundle
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface picomips_sequencer_if #(
  parameter int Psize = picomips_pkg::PSIZE_DEFAULT
);

  logic             PCincr;
  logic             PCrelbranch;
  logic [Psize-1:0] branch_off;
  logic             w_dec;
  logic             mul_dec;
  logic             readyin_raw;
  logic             readyin;
  logic [Psize-1:0] PCout;
  logic             w_en;
  logic             stall;

  // Decoder / environment side
  modport master (
    output PCincr, PCrelbranch, branch_off, w_dec, mul_dec, readyin_raw,
    input  readyin, PCout, w_en, stall
  );

  // Sequencer side
  modport slave (
    input  PCincr, PCrelbranch, branch_off, w_dec, mul_dec, readyin_raw,
    output readyin, PCout, w_en, stall
  );

endinterface

`default_nettype wire

// File: rtl/sync_chain.sv
// ---------------------------------------------------------------------------
// sync_chain : SYNC_STAGES-deep flop chain for an asynchronous level input
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sync_chain #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic n_reset,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/picomips_sequencer.sv
// ---------------------------------------------------------------------------
// picomips_sequencer : PC owner, MULI stall sequencer and readyin synchroniser
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module picomips_sequencer
  import picomips_pkg::*;
#(
  parameter int Psize       = PSIZE_DEFAULT,
  parameter int MUL_CYCLES  = MUL_CYCLES_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                n_reset,
  picomips_sequencer_if.slave bus
);

  localparam int               CNT_W       = $clog2(MUL_CYCLES) + 1;
  localparam bit               MUL_STALLS  = (MUL_CYCLES > 1);
  localparam logic [CNT_W-1:0] CNT_INIT    = MUL_STALLS ? CNT_W'(MUL_CYCLES - 2) : '0;

  seq_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [Psize-1:0] pc_q,    pc_d;
  logic             wen;
  logic             stl;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    wen     = 1'b0;
    stl     = 1'b0;
    case (state_q)
      RUN: begin
        if (MUL_STALLS && bus.mul_dec) begin
          state_d = MULW;
          cnt_d   = CNT_INIT;
          stl     = 1'b1;
        end else begin
          wen = bus.w_dec;
          // Equal widths make modular addition identical to a sign-extended add.
          if (bus.PCrelbranch) begin
            pc_d = pc_q + bus.branch_off;
          end else if (bus.PCincr) begin
            pc_d = pc_q + Psize'(1);
          end
        end
      end
      MULW: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
          stl   = 1'b1;
        end else begin
          wen     = bus.w_dec;
          pc_d    = pc_q + Psize'(1);
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
    end
  end

  // Reset suppresses both strobes so an abandoned multiply can never write.
  assign bus.w_en  = n_reset & wen;
  assign bus.stall = n_reset & stl;
  assign bus.PCout = pc_q;

  sync_chain #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_ready_sync (
    .clk     (clk),
    .n_reset (n_reset),
    .d_i     (bus.readyin_raw),
    .q_o     (bus.readyin)
  );

endmodule

`default_nettype wire

// File: tb/tb_picomips_sequencer.sv
// ---------------------------------------------------------------------------
// tb_picomips_sequencer : scoreboard bench with instruction-level PC model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_picomips_sequencer;

  localparam int PS   = 6;
  localparam int MOD  = 1 << PS;
  localparam int MC   = 3;
  localparam int SYNC = 2;

  typedef struct {
    logic [PS-1:0] pc;
    bit            ok;
    logic          rdy;
    logic          w_en;
    logic          stall;
  } exp_t;

  logic clk = 1'b0;
  logic n_reset;
  int   total = 0;
  int   bad   = 0;
  exp_t sb_q[$];
  bit   stim_done = 1'b0;

  // reference model: program counter, remaining MULI occupancy, readyin history
  int   m_pc    = 0;
  int   m_busy  = 0;
  bit   m_known = 1'b0;
  int   m_hist[$];
  logic last_rdy;

  picomips_sequencer_if #(.Psize(PS)) bus ();

  picomips_sequencer #(
    .Psize       (PS),
    .MUL_CYCLES  (MC),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk     (clk),
    .n_reset (n_reset),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic cycle(input logic nr, input logic incr, input logic rel,
                       input logic [PS-1:0] off, input logic w, input logic mul,
                       input logic raw, input bit rel_from_rdy);
    exp_t e;
    int   off_s;
    logic rel_v;
    @(negedge clk);
    last_rdy = bus.readyin;
    rel_v    = rel_from_rdy ? bus.readyin : rel;
    n_reset         = nr;
    bus.PCincr      = incr;
    bus.PCrelbranch = rel_v;
    bus.branch_off  = off;
    bus.w_dec       = w;
    bus.mul_dec     = mul;
    bus.readyin_raw = raw;

    e.pc    = PS'(m_pc);
    e.ok    = m_known;
    e.rdy   = m_hist[0][0];
    e.w_en  = 1'b0;
    e.stall = 1'b0;
    if (!nr) begin
      m_pc    = 0;
      m_busy  = 0;
      m_known = 1'b1;
      for (int i = 0; i < SYNC; i++) m_hist[i] = 0;
    end else begin
      if (m_busy == 0 && mul && MC > 1) m_busy = MC;
      if (m_busy > 0) begin
        if (m_busy == 1) begin
          e.w_en = w;
          m_pc   = (m_pc + 1) % MOD;
        end else begin
          e.stall = 1'b1;
        end
        m_busy--;
      end else begin
        e.w_en = w;
        off_s  = int'(off);
        if (off_s >= MOD / 2) off_s -= MOD;
        if (rel_v)     m_pc = (m_pc + off_s + MOD) % MOD;
        else if (incr) m_pc = (m_pc + 1) % MOD;
      end
      void'(m_hist.pop_front());
      m_hist.push_back(int'(raw));
    end
    sb_q.push_back(e);
  endtask

  // monitor: one output presentation per cycle, sampled mid-low-phase
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        total++;
        if (bus.w_en !== e.w_en) begin
          bad++;
          $display("FAIL w_en: got %b want %b at %0t", bus.w_en, e.w_en, $time);
        end
        total++;
        if (bus.stall !== e.stall) begin
          bad++;
          $display("FAIL stall: got %b want %b at %0t", bus.stall, e.stall, $time);
        end
        if (e.ok) begin
          total++;
          if (bus.PCout !== e.pc) begin
            bad++;
            $display("FAIL PCout: got %0d want %0d at %0t", bus.PCout, e.pc, $time);
          end
          total++;
          if (bus.readyin !== e.rdy) begin
            bad++;
            $display("FAIL readyin: got %b want %b at %0t", bus.readyin, e.rdy, $time);
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int first;
    for (int i = 0; i < SYNC; i++) m_hist.push_back(0);
    n_reset = 1'b0;
    bus.PCincr = 1'b0; bus.PCrelbranch = 1'b0; bus.branch_off = '0;
    bus.w_dec = 1'b0; bus.mul_dec = 1'b0; bus.readyin_raw = 1'b0;

    // reset with random request inputs
    repeat (2) cycle(1'b0, 1'($urandom), 1'($urandom), PS'($urandom), 1'($urandom),
                     1'($urandom), 1'b0, 1'b0);
    repeat (5) cycle(1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    // 5 -> 63 -> wrap to 0 -> 1 -> 2
    cycle(1'b1, 1'b0, 1'b1, 6'h3A, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) cycle(1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    // 2 - 2 -> 0, +1, 1 - 2 -> 63, both requests: 63 + 5 -> 4
    cycle(1'b1, 1'b0, 1'b1, 6'h3E, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 6'h3E, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 6'h05, 1'b0, 1'b0, 1'b0, 1'b0);
    // MULI at PC 4, instruction held for its occupancy
    repeat (MC) cycle(1'b1, 1'b1, 1'b1, 6'h07, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);

    // WAIT loop: branch taken once the synchronised switch reads high
    repeat (3) cycle(1'b1, 1'b0, 1'b0, 6'h03, 1'b0, 1'b0, 1'b0, 1'b1);
    first = -1;
    for (int k = 0; k < 8; k++) begin
      cycle(1'b1, 1'b0, 1'b0, 6'h03, 1'b0, 1'b0, 1'b1, 1'b1);
      if (first < 0 && last_rdy === 1'b1) first = k;
    end
    total++;
    if (first != SYNC) begin
      bad++;
      $display("FAIL readyin_latency: got %0d edges want %0d", first, SYNC);
    end

    // reset during the final multiply cycle
    cycle(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);

    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      cycle(($urandom_range(0, 49) != 0), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 2) == 0), PS'($urandom), 1'($urandom),
            ($urandom_range(0, 4) == 0), 1'($urandom_range(0, 7) == 0) ^ bus.readyin_raw,
            1'b0);
    end

    repeat (3) @(negedge clk);
    #5;
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d left want 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
